// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing for the fifo_rd_stream prefetch path.
package fifo_stream_pkg;

  localparam int unsigned BUF_DEPTH   = 3;
  localparam int unsigned OCC_W       = 2;
  localparam int unsigned PTR_W       = 2;
  localparam int unsigned STALL_CNT_W = 16;

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Ring pointer advance, wrapping modulo BUF_DEPTH
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO pop side plus valid/ready stream side of fifo_rd_stream.
interface fifo_rd_stream_if #(
  parameter int unsigned WIDTH = 32
);

  logic             fifo_empty;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_pop, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_pop, m_valid, m_data, m_last
  );

endinterface

// File: rtl/stream_prefetch_buf.sv
// Three-entry in-order ring buffer absorbing the FIFO's read latency.
module stream_prefetch_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head_data,
  output occ_t             occ
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  occ_t             occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (wr_en) begin
      mem_d[tail_q] = wr_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (rd_en) begin
      head_d = ptr_inc(head_q);
    end
    // Simultaneous write and read leaves occupancy unchanged
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops sync_fifo into a prefetch buffer and presents a burst-framed valid/ready stream.
// Optional stall counter port is enabled by defining FIFO_RD_PERF_EN.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned BURST_LEN = 4,
  localparam int unsigned BIDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_rd_stream_if.master       bus,
  output logic [BIDX_W-1:0]      beat_idx
`ifdef FIFO_RD_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  logic              inflight_q, inflight_d;
  logic [BIDX_W-1:0] beat_q, beat_d;
  occ_t              occ;
  logic [WIDTH-1:0]  head_data;
  logic              valid;
  logic              hs;
  logic              last;
  logic              pop;

  stream_prefetch_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (inflight_q),
    .wr_data   (bus.fifo_rd_data),
    .rd_en     (hs),
    .head_data (head_data),
    .occ       (occ)
  );

  // Pop only from registered occupancy so m_ready never reaches fifo_pop
  always_comb begin
    valid      = (occ != '0);
    hs         = valid && bus.m_ready;
    last       = (beat_q == BIDX_W'(BURST_LEN - 1));
    pop        = !rst && !bus.fifo_empty &&
                 ((3'({1'b0, occ}) + 3'(inflight_q)) < 3'(BUF_DEPTH));
    inflight_d = pop;
    beat_d     = beat_q;
    if (hs) begin
      beat_d = last ? '0 : beat_q + BIDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
    end
  end

  assign bus.fifo_pop = pop;
  assign bus.m_valid  = valid;
  assign bus.m_data   = head_data;
  assign bus.m_last   = last;
  assign beat_idx     = beat_q;

`ifdef FIFO_RD_PERF_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  // Saturating count of cycles with a beat offered but not accepted
  always_comb begin
    stall_d = stall_q;
    if (valid && !bus.m_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Downstream consumer of sync_fifo. It drives the FIFO's pop side and presents the popped words as a valid/ready stream with burst framing.
- It hides the FIFO's one-cycle read latency behind a 3-entry prefetch buffer, giving full throughput with no combinational path from m_ready to fifo_pop.
- It sits between sync_fifo and any valid/ready sink.

Parameters:
- WIDTH, 32, data width; must match the upstream sync_fifo WIDTH.
- BURST_LEN, 4, beats per burst; m_last marks the final beat; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fifo_empty  in  1  sync_fifo empty flag
- fifo_pop  out  1  sync_fifo pop request
- fifo_rd_data  in  WIDTH  sync_fifo read data; valid the cycle after pop
- m_valid  out  1  stream beat valid
- m_ready  in  1  sink ready
- m_data  out  WIDTH  stream beat data
- m_last  out  1  last beat of burst
- beat_idx  out  $clog2(BURST_LEN) (min 1)  index of current head beat within burst
- stall_cnt  out  16  present only with FIFO_RD_PERF_EN

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: m_valid=0, fifo_pop=0, beat_idx=0, m_last=0 (1 if BURST_LEN==1), m_data=0, occ=0, inflight=0.
- FIFO read contract: a pop in cycle N puts the word on fifo_rd_data in cycle N+1. It is captured into the buffer at the end of N+1.
- inflight: 1-bit register = fifo_pop of the previous cycle.
- occ: buffer occupancy, range 0..3 (BUF_DEPTH=3).
- fifo_pop = !rst && !fifo_empty && (occ + inflight < 3). Both occ and inflight are registered, so there is no m_ready→fifo_pop path.
- Guarantees: never pops when empty; never overflows the buffer.
- Buffer: in-order ring.
  - Write when inflight=1.
  - Read when m_valid && m_ready.
  - Simultaneous write and read leaves occ unchanged.
  - Head and tail pointers wrap modulo 3.
- m_valid = (occ != 0); m_data = head entry.
- Once m_valid=1, m_data, m_last and beat_idx hold stable until the handshake.
- Latency: first pop at cycle N gives m_valid at N+2.
- Steady state with m_ready=1 and FIFO non-empty: 1 beat/cycle (occ=1, inflight=1, pop every cycle).
- Backpressure: with m_ready=0, at most 3 words are popped, then fifo_pop=0 until space frees.
- Burst counter beat_idx:
  - Increments on each handshake; wraps to 0 after the handshake at BURST_LEN-1.
  - m_last = (beat_idx == BURST_LEN-1).
  - Bursts span FIFO-empty gaps; the counter resets only on rst.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - beat_idx returns to 0.
  - sync_fifo shares rst and is cleared in the same cycle, so no orphaned pop exists.
- fifo_rd_data is ignored when inflight=0; X on it is then harmless.

Optional Feature:
- Macro: FIFO_RD_PERF_EN.
- When defined:
  - stall_cnt port exists; counts cycles with m_valid=1 && m_ready=0.
  - Saturates at 0xFFFF; cleared by rst.
- When undefined: port and counter are absent, with no other behavioural change.

Decomposition:
- Package fifo_stream_pkg:
  - BUF_DEPTH=3 localparam.
  - occ_t (2-bit) and ptr_t typedefs.
  - STALL_CNT_W=16.
- Sub-module stream_prefetch_buf:
  - 3-entry ring buffer with wr_en/wr_data/rd_en/head_data/occ.
  - Instantiated once; control and burst counter stay in fifo_rd_stream.

Test Plan:
- Reset, fifo_empty=1 for 10 cycles -> fifo_pop=0, m_valid=0, beat_idx=0 throughout.
- Preload 8 words 0x10..0x17, m_ready=1 -> first pop cycle N, m_valid at N+2, 8 back-to-back beats in order, m_last on 0x13 and 0x17.
- Preloaded 8 words, m_ready=0 for 20 cycles -> exactly 3 pops then fifo_pop=0, m_data held 0x10. Release -> 0x10..0x17 with no loss or duplicates.
- Random fifo_empty and m_ready for 1000 beats against a scoreboard -> order preserved, no pop while empty, occ ≤3, m_data stable under stall.
- Assert rst after 2 beats of a burst with inflight=1 -> next cycle m_valid=0, beat_idx=0. The first post-reset burst has m_last on its 4th beat.
- FIFO_RD_PERF_EN: m_valid=1, m_ready=0 for 10 cycles -> stall_cnt=10. Force a 70000-cycle stall -> stall_cnt=0xFFFF.
